// File: rtl/mod12_sequence_checker.sv
// Health monitor for a modulo-MOD counter: verifies +1 steps, reports lock,
// counts wrap-arounds while locked and latches a sticky error with a cause code.
module mod12_sequence_checker #(
  parameter int MOD         = 12,
  parameter int WIDTH       = 4,
  parameter int WRAP_W      = 16,
  parameter int LOCK_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q,
  input  logic              en,
  input  logic              clr_err,
  output logic              locked,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_q
);

  localparam int CNT_W = $clog2(LOCK_THRESH + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_have_prev;
  logic [CNT_W-1:0] r_match_cnt;

  logic [WIDTH-1:0] w_exp;
  logic             w_range_err;
  logic             w_seq_err;
  logic             w_wrap_sat;

  assign w_exp       = (last_q == WIDTH'(MOD - 1)) ? '0 : last_q + WIDTH'(1);
  // One extra bit so the range check stays correct even if MOD == 2**WIDTH.
  assign w_range_err = ({1'b0, q} >= (WIDTH + 1)'(MOD));
  assign w_seq_err   = !w_range_err && r_have_prev && (q != w_exp);
  assign w_wrap_sat  = &wrap_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SEARCH;
      r_have_prev <= 1'b0;
      r_match_cnt <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      wrap_pulse  <= 1'b0;
      wrap_count  <= '0;
      last_q      <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      // A clear is applied first so that an error detected on this same edge overrides it.
      if (clr_err) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end
      if (r_state == FAULT && clr_err) begin
        r_state     <= SEARCH;
        r_match_cnt <= '0;
        r_have_prev <= 1'b1;
      end
      if (en) begin
        last_q <= q;
        case (r_state)
          SEARCH: begin
            if (!r_have_prev) begin
              r_have_prev <= 1'b1;
            end else if (w_range_err || w_seq_err) begin
              r_match_cnt <= '0;
              if (w_range_err) begin
                err      <= 1'b1;
                err_code <= 2'b10;
              end
            end else if (r_match_cnt == CNT_W'(LOCK_THRESH - 1)) begin
              r_match_cnt <= CNT_W'(LOCK_THRESH);
              r_state     <= LOCKED;
              locked      <= 1'b1;
            end else begin
              r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
          end
          LOCKED: begin
            if (w_range_err || w_seq_err) begin
              r_state  <= FAULT;
              locked   <= 1'b0;
              err      <= 1'b1;
              err_code <= w_range_err ? 2'b10 : 2'b01;
            end else if (w_exp == '0) begin
              wrap_pulse <= 1'b1;
              if (!w_wrap_sat) begin
                wrap_count <= wrap_count + WRAP_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mod12_sequence_checker.md
Name: mod12_sequence_checker

Overview:
Downstream monitor for the modulo-12 counter. Samples the counter's 4-bit output every enabled clock and checks that it advances by exactly one, modulo MOD. It reports lock status, counts completed wrap-arounds and raises a sticky error with a cause code.
Used in-system as a health monitor and in benches as a self-checking scoreboard.

Parameters:
MOD, 12, counter modulus; legal q values are 0..MOD-1
WIDTH, 4, width of the monitored count bus
WRAP_W, 16, width of the wrap counter
LOCK_THRESH, 3, consecutive correct increments required to assert locked

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  one clock; reset is asynchronous and active-low
q  input  WIDTH  counter value, sampled on rising edge when en=1
en  input  1  sample enable; en=0 freezes all state
clr_err  input  1  clears err/err_code; exits FAULT
locked  output  1  sequence verified
err  output  1  sticky error flag
err_code  output  2  00 none, 01 sequence break, 10 out-of-range (q>=MOD)
wrap_pulse  output  1  one-cycle pulse per MOD-1 -> 0 transition while locked
wrap_count  output  WRAP_W  number of wraps seen while locked, saturating
last_q  output  WIDTH  most recent sampled q

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - state=SEARCH, have_prev=0, match_cnt=0.
  - locked=0, err=0, err_code=00, wrap_pulse=0, wrap_count=0, last_q=0.
- Latency: all outputs registered; the effect of a sample appears one cycle after the edge that samples it.
- en=0: no state, counter or output changes, except wrap_pulse, which returns to 0.
- Per sample definitions:
  - exp = (last_q == MOD-1) ? 0 : last_q+1.
  - range_err = (q >= MOD).
  - seq_err = !range_err && have_prev && (q != exp).
  - last_q <= q on every sample, including bad ones.
- SEARCH:
  - First sample after reset: sets have_prev=1 only; no check is performed.
  - Correct increment: match_cnt++.
  - Any error: match_cnt=0.
  - range_err additionally sets err=1 and err_code=10; state stays SEARCH. A seq_err in SEARCH only resets match_cnt.
  - When match_cnt reaches LOCK_THRESH: go to LOCKED, locked=1.
- LOCKED:
  - Correct increment: stay in LOCKED.
  - If exp==0 (wrap): wrap_pulse=1 for one cycle and wrap_count++, saturating at all-ones.
  - Any error: go to FAULT, locked=0, err=1.
  - err_code=10 if range_err, else 01. Range has priority over sequence.
- FAULT:
  - locked=0; wrap_count frozen; samples update last_q only.
  - Leave FAULT only on clr_err=1: go to SEARCH with match_cnt=0 and have_prev=1. The sample taken on that edge becomes the new reference.
- clr_err semantics:
  - clr_err=1 on a clock edge clears err and err_code in any state.
  - If a new error is detected on the same edge, the new error wins: err=1 and err_code reflects that error.
  - clr_err is effective even when en=0; it does not advance the sequence check.
- wrap_count is never cleared except by reset.
- Reset asserted mid-operation: immediate return to reset values. The first sample after release is treated as the first sample (no check).

Test Plan:
1. Reset release, en=1, q=0,1,2,3,4 -> locked=0 through the sample of 2; locked=1 the cycle after sampling 3; err=0, wrap_count=0.
2. 30 consecutive samples 0..11,0..11,0..5 from reset -> exactly two one-cycle wrap_pulses, each one cycle after sampling 0 following 11; final wrap_count=2, err=0, last_q=5.
3. Locked, expected 8, drive q=5 -> next cycle locked=0, err=1, err_code=01; further valid samples leave wrap_count unchanged and err stays 1.
4. Locked, drive q=13 -> err_code=10, locked=0. In SEARCH, q=14 -> err=1, err_code=10, locked stays 0.
5. In FAULT, clr_err=1 with q=4, then q=5,6,7 -> err=0 and err_code=00 the cycle after the clr_err edge; locked=1 the cycle after sampling 7. Separately, clr_err coinciding with q=12 in SEARCH -> err stays 1, err_code=10.
6. Locked mid-count with wrap_count=3, pulse reset low between clock edges -> all outputs 0 immediately. After release, en=0 for 5 cycles -> no change; then q=9,10,11,0 -> locked=1, wrap_count stays 0.
